// File: rtl/alu_pkg.sv
// Shared ALU datapath types: adder geometry, the machine word and the
// arithmetic status flags consumed by the flag register.
package alu_pkg;
  localparam int ADDER_WIDTH = 16;
  localparam int ADDER_GROUP = 4;

  typedef logic [ADDER_WIDTH-1:0] word_t;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
  } flags_t;
endpackage

// File: rtl/adder_16bit_cla_group.sv
// One carry-lookahead group: local sums from the group carry-in, plus the
// group generate/propagate terms used by the second-level lookahead.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             gg,
  output logic             gp
);
  logic [GROUP-1:0] w_g;
  logic [GROUP-1:0] w_p;
  logic [GROUP-1:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    for (int i = 0; i < GROUP - 1; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  // Group generate is independent of cin so the upper level can look ahead.
  always_comb begin
    gg = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      gg = w_g[i] | (w_p[i] & gg);
    end
  end

  assign gp  = &w_p;
  assign sum = w_p ^ w_c;
endmodule

// File: rtl/adder_16bit.sv
// Registered two-level carry-lookahead adder with carry, signed-overflow and
// zero status; results appear one clock after a valid operand pair.
module adder_16bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int GROUP = ADDER_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             V,
  output logic             Z
);
  localparam int NG = WIDTH / GROUP;

  logic [NG-1:0]    w_gg;
  logic [NG-1:0]    w_gp;
  logic [NG:0]      w_gc;
  logic [WIDTH-1:0] w_sum;
  flags_t           w_flags;

  logic             r_vld;
  logic [WIDTH-1:0] r_sum;
  flags_t           r_flags;

  for (genvar j = 0; j < NG; j++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .a   (A[j*GROUP +: GROUP]),
      .b   (B[j*GROUP +: GROUP]),
      .cin (w_gc[j]),
      .sum (w_sum[j*GROUP +: GROUP]),
      .gg  (w_gg[j]),
      .gp  (w_gp[j])
    );
  end

  // Second-level lookahead: group carry-ins from C_in and group G/P.
  always_comb begin
    w_gc    = '0;
    w_gc[0] = C_in;
    for (int j = 0; j < NG; j++) begin
      w_gc[j+1] = w_gg[j] | (w_gp[j] & w_gc[j]);
    end
  end

  assign w_flags.c = w_gc[NG];
  assign w_flags.v = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
  assign w_flags.z = (w_sum == '0);

  // Result registers hold across idle cycles; only the valid bit tracks in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_sum   <= '0;
      r_flags <= '0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_sum   <= w_sum;
        r_flags <= w_flags;
      end
    end
  end

  assign out_valid = r_vld;
  assign S         = r_sum;
  assign C_out     = r_flags.c;
  assign V         = r_flags.v;
  assign Z         = r_flags.z;
endmodule

// File: tb/tb_adder_16bit.sv
// Directed-vector bench for adder_16bit: reset, low-range sweep, wrap,
// overflow, group carry chains and back-to-back/hold behaviour.
module tb_adder_16bit;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] A;
  logic [15:0] B;
  logic        C_in;
  logic        out_valid;
  logic [15:0] S;
  logic        C_out;
  logic        V;
  logic        Z;

  int n_vec;
  int n_err;

  adder_16bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .C_in      (C_in),
    .out_valid (out_valid),
    .S         (S),
    .C_out     (C_out),
    .V         (V),
    .Z         (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view {out_valid, C_out, V, Z, S} = 20 bits.
  logic [19:0] obs;
  assign obs = {out_valid, C_out, V, Z, S};

  task automatic test_reset();
    logic [19:0] exp;
    in_valid = 1'b1; A = 16'd5; B = 16'd7; C_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      exp = 20'h0;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, obs, exp);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    A = 16'd3; B = 16'd4; C_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 16'd7};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL reset_first_op got=%h want=%h", obs, exp);
    end
    #2 rst_n = 1'b0;
    #1;
    exp = 20'h0;
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL reset_async got=%h want=%h", obs, exp);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [19:0] exp;
    int          s;
    for (int a = 0; a < 100; a++) begin
      for (int b = 0; b < 100; b++) begin
        for (int c = 0; c < 2; c++) begin
          A = 16'(a); B = 16'(b); C_in = 1'(c); in_valid = 1'b1;
          @(posedge clk); #1;
          s   = a + b + c;
          exp = {1'b1, 1'b0, 1'b0, (s == 0), 16'(s)};
          n_vec++;
          if (obs !== exp) begin
            n_err++;
            $display("FAIL sweep a=%0d b=%0d c=%0d got=%h want=%h", a, b, c, obs, exp);
          end
        end
      end
    end
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [19:0] exp;
  } vec_t;

  task automatic test_boundaries();
    vec_t v[8];
    // exp = {out_valid, C_out, V, Z, S}
    v[0] = '{16'hFFFF, 16'h0001, 1'b0, {4'b1101, 16'h0000}};
    v[1] = '{16'hFFFF, 16'hFFFF, 1'b1, {4'b1100, 16'hFFFF}};
    v[2] = '{16'h7FFF, 16'h0001, 1'b0, {4'b1010, 16'h8000}};
    v[3] = '{16'h8000, 16'h8000, 1'b0, {4'b1111, 16'h0000}};
    v[4] = '{16'h0FFF, 16'h0001, 1'b0, {4'b1000, 16'h1000}};
    v[5] = '{16'h00FF, 16'h0000, 1'b1, {4'b1000, 16'h0100}};
    v[6] = '{16'h0000, 16'h0000, 1'b1, {4'b1000, 16'h0001}};
    v[7] = '{16'hFFFF, 16'h0000, 1'b1, {4'b1101, 16'h0000}};
    for (int i = 0; i < 8; i++) begin
      A = v[i].a; B = v[i].b; C_in = v[i].c; in_valid = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (obs !== v[i].exp) begin
        n_err++;
        $display("FAIL boundary idx=%0d a=%h b=%h c=%0b got=%h want=%h",
                 i, v[i].a, v[i].b, v[i].c, obs, v[i].exp);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    vec_t        v[3];
    logic [19:0] hold;
    v[0] = '{16'h1234, 16'h1111, 1'b0, {4'b1000, 16'h2345}};
    v[1] = '{16'h8000, 16'h7FFF, 1'b1, {4'b1101, 16'h0000}};
    v[2] = '{16'h4000, 16'h4000, 1'b0, {4'b1010, 16'h8000}};
    for (int i = 0; i < 3; i++) begin
      A = v[i].a; B = v[i].b; C_in = v[i].c; in_valid = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (obs !== v[i].exp) begin
        n_err++;
        $display("FAIL b2b idx=%0d got=%h want=%h", i, obs, v[i].exp);
      end
    end
    hold = {4'b0010, 16'h8000};
    in_valid = 1'b0; A = 16'hFFFF; B = 16'hFFFF; C_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (obs !== hold) begin
        n_err++;
        $display("FAIL hold cyc=%0d got=%h want=%h", i, obs, hold);
      end
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    C_in     = 1'b0;
    test_reset();
    test_sweep();
    test_boundaries();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
